icw_ocw_sequencer: RTL
======================

Name: icw_ocw_sequencer

Overview:
- Command-word sequencer for the 8259 PIC. It sits behind the control bus decoder, which produces the raw write strobes and the latched 8-bit internal bus.
- Tracks the ICW1→ICW2→(ICW3)→(ICW4) initialization sequence and disambiguates A1=1 writes (ICW2/3/4 vs OCW1) by state.
- Holds all configuration registers: vector base, cascade, mode bits, IMR, read-select and special mask.
- Issues one-cycle command pulses (OCW2, poll, init-clear) to the priority resolver and in-service logic.

Parameters:
IMR_INIT, 8'h00, IMR value after reset and after every ICW1 commit

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
write_ICW_1  input  1  level strobe from control bus: A1=0, D4=1
write_ICW2_4  input  1  level strobe: A1=1 write (same condition as write_OCW1)
write_OCW1  input  1  level strobe: A1=1 write
write_OCW2  input  1  level strobe: A1=0, D4=0, D3=0
write_OCW3  input  1  level strobe: A1=0, D4=0, D3=1
internal_bus  input  8  latched write data from control bus
init_done  output  1  1 = initialization sequence complete (state READY)
ltim  output  1  ICW1 D3, level-triggered mode
single  output  1  ICW1 D1, single (no cascade)
ic4  output  1  ICW1 D0, ICW4 needed
vector_base  output  5  ICW2 D7..D3
icw3  output  8  ICW3 raw (master slave-map or slave ID in [2:0])
upm  output  1  ICW4 D0
aeoi  output  1  ICW4 D1
buf_ms  output  2  ICW4 D3..D2 {BUF,M/S}
sfnm  output  1  ICW4 D4
imr  output  8  interrupt mask register (OCW1)
read_isr_sel  output  1  0 = read IRR, 1 = read ISR
smm  output  1  special mask mode
ocw2_valid  output  1  one-cycle pulse on OCW2 commit
ocw2_cmd  output  3  OCW2 D7..D5 {R,SL,EOI}, valid with ocw2_valid
ocw2_level  output  3  OCW2 D2..D0, valid with ocw2_valid
poll_pulse  output  1  one-cycle pulse on OCW3 commit with P=1
init_clear  output  1  one-cycle pulse on ICW1 commit (resolver/ISR clear)

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0):
  - state=UNINIT; imr=IMR_INIT.
  - All other outputs 0, including init_done and the pulses.
  - Reset mid-sequence abandons the sequence.
- Commit timing:
  - Each clk, the sampled strobe vector is registered (strb_q).
  - While any strobe is 1, internal_bus is captured into data_q.
  - A write commits on the clk edge where strb_q≠0 and the current strobes are all 0 (trailing edge of WR). The commit uses strb_q and data_q.
  - Register outputs change at that edge. Pulses are high for the following cycle only.
- A write is one commit regardless of how many cycles the strobe stays high.
- States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- ICW1 commit (any state, including mid-sequence):
  - Load ltim/single/ic4 from data_q.
  - imr=IMR_INIT; smm=0; read_isr_sel=0.
  - Clear icw3, upm, aeoi, buf_ms, sfnm.
  - init_done=0; init_clear pulse; next state WAIT_ICW2.
- A1=1 commit (write_ICW2_4/write_OCW1), by state:
  - WAIT_ICW2: vector_base=data_q[7:3]. Next: single=0→WAIT_ICW3; else ic4=1→WAIT_ICW4; else READY.
  - WAIT_ICW3: icw3=data_q. Next: ic4=1→WAIT_ICW4, else READY.
  - WAIT_ICW4: upm=D0, aeoi=D1, buf_ms=D3..D2, sfnm=D4. Next READY.
  - READY: imr=data_q (OCW1). State unchanged.
  - UNINIT: ignored.
- init_done=1 in exactly the cycles state==READY.
- OCW2 commit: READY only. ocw2_valid=1 with ocw2_cmd=D7..D5 and ocw2_level=D2..D0.
- OCW3 commit: READY only.
  - If D1 (RR)=1: read_isr_sel=D0 (RIS); otherwise unchanged.
  - If D6 (ESMM)=1: smm=D5; otherwise unchanged.
  - If D2 (P)=1: poll_pulse.
- OCW2/OCW3 commits in UNINIT or any WAIT state: ignored, no pulse, no state change.
- Simultaneous strobe bits are not produced by the decoder, except ICW2_4 with OCW1 (identical), which is treated as a single A1=1 write.
- A new write beginning in the cycle right after a commit is handled normally; back-to-back writes need ≥1 idle cycle between strobes.

Test Plan:
- Reset, then ICW1=0x13, ICW2=0x48, ICW4=0x03 → after the ICW2 commit state is WAIT_ICW4. After the ICW4 commit: init_done=1, vector_base=5'h09, upm=1, aeoi=1, single=1, imr=0x00, init_clear seen exactly once.
- ICW1=0x11, ICW2=0x20, ICW3=0x04, ICW4=0x01 → icw3=0x04, init_done=1 only after the ICW4 commit. ICW1=0x10, ICW2=0x20, ICW3=0x04 → READY after ICW3 with upm=0.
- READY, A1=1 write 0xA5 held 4 cycles → imr=0xA5, single commit, vector_base unchanged. OCW2 0x63 → one ocw2_valid with cmd=3'b011, level=3'b011.
- OCW3 0x0B → read_isr_sel=1. OCW3 0x68 → smm=1. OCW3 0x0C → poll_pulse once, read_isr_sel still 1.
- Mid-sequence ICW1 (in WAIT_ICW3), then OCW2 0x20 → init_done=0, state WAIT_ICW2, imr=IMR_INIT, no ocw2_valid.
- Assert rst_n=0 during a held strobe in WAIT_ICW4 → all outputs reset immediately. After release, the strobe's trailing edge produces no commit.

Source files
------------

// File: rtl/icw_ocw_sequencer.sv
// Command-word sequencer for an 8259-style PIC.
// Tracks ICW1..ICW4 initialization, disambiguates A1=1 writes by state,
// holds configuration registers and issues one-cycle command pulses.
module icw_ocw_sequencer #(
  parameter logic [7:0] IMR_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       write_ICW_1,
  input  logic       write_ICW2_4,
  input  logic       write_OCW1,
  input  logic       write_OCW2,
  input  logic       write_OCW3,
  input  logic [7:0] internal_bus,
  output logic       init_done,
  output logic       ltim,
  output logic       single,
  output logic       ic4,
  output logic [4:0] vector_base,
  output logic [7:0] icw3,
  output logic       upm,
  output logic       aeoi,
  output logic [1:0] buf_ms,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic       read_isr_sel,
  output logic       smm,
  output logic       ocw2_valid,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       poll_pulse,
  output logic       init_clear
);

  localparam int unsigned NUM_STRB = 5;

  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  state_t state, state_d;

  logic [NUM_STRB-1:0] strb, strb_q;
  logic [7:0]          data_q;
  logic                armed;
  logic                commit;
  logic                a1_write;

  logic       ltim_d, single_d, ic4_d, upm_d, aeoi_d, sfnm_d;
  logic [4:0] vector_base_d;
  logic [7:0] icw3_d, imr_d;
  logic [1:0] buf_ms_d;
  logic       read_isr_sel_d, smm_d;
  logic       ocw2_valid_d, poll_pulse_d, init_clear_d;
  logic [2:0] ocw2_cmd_d, ocw2_level_d;

  // Bit order: {OCW3, OCW2, OCW1, ICW2_4, ICW1}
  assign strb     = {write_OCW3, write_OCW2, write_OCW1, write_ICW2_4, write_ICW_1};
  assign commit   = (strb_q != '0) && (strb == '0);
  assign a1_write = strb_q[1] | strb_q[2];

  // Strobe/data capture; armed blocks a strobe already high when reset is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_q <= '0;
      data_q <= '0;
      armed  <= 1'b0;
    end else begin
      strb_q <= armed ? strb : '0;
      if (strb == '0) armed <= 1'b1;
      if (strb != '0) data_q <= internal_bus;
    end
  end

  // State and configuration register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= UNINIT;
      init_done    <= 1'b0;
      ltim         <= 1'b0;
      single       <= 1'b0;
      ic4          <= 1'b0;
      vector_base  <= '0;
      icw3         <= '0;
      upm          <= 1'b0;
      aeoi         <= 1'b0;
      buf_ms       <= '0;
      sfnm         <= 1'b0;
      imr          <= IMR_INIT;
      read_isr_sel <= 1'b0;
      smm          <= 1'b0;
      ocw2_valid   <= 1'b0;
      ocw2_cmd     <= '0;
      ocw2_level   <= '0;
      poll_pulse   <= 1'b0;
      init_clear   <= 1'b0;
    end else begin
      state        <= state_d;
      init_done    <= (state_d == READY);
      ltim         <= ltim_d;
      single       <= single_d;
      ic4          <= ic4_d;
      vector_base  <= vector_base_d;
      icw3         <= icw3_d;
      upm          <= upm_d;
      aeoi         <= aeoi_d;
      buf_ms       <= buf_ms_d;
      sfnm         <= sfnm_d;
      imr          <= imr_d;
      read_isr_sel <= read_isr_sel_d;
      smm          <= smm_d;
      ocw2_valid   <= ocw2_valid_d;
      ocw2_cmd     <= ocw2_cmd_d;
      ocw2_level   <= ocw2_level_d;
      poll_pulse   <= poll_pulse_d;
      init_clear   <= init_clear_d;
    end
  end

  // Next-state and next-register decode on each committed write
  always_comb begin
    state_d        = state;
    ltim_d         = ltim;
    single_d       = single;
    ic4_d          = ic4;
    vector_base_d  = vector_base;
    icw3_d         = icw3;
    upm_d          = upm;
    aeoi_d         = aeoi;
    buf_ms_d       = buf_ms;
    sfnm_d         = sfnm;
    imr_d          = imr;
    read_isr_sel_d = read_isr_sel;
    smm_d          = smm;
    ocw2_valid_d   = 1'b0;
    ocw2_cmd_d     = ocw2_cmd;
    ocw2_level_d   = ocw2_level;
    poll_pulse_d   = 1'b0;
    init_clear_d   = 1'b0;

    if (commit) begin
      if (strb_q[0]) begin
        // ICW1 restarts initialization from any state
        ltim_d         = data_q[3];
        single_d       = data_q[1];
        ic4_d          = data_q[0];
        imr_d          = IMR_INIT;
        smm_d          = 1'b0;
        read_isr_sel_d = 1'b0;
        icw3_d         = '0;
        upm_d          = 1'b0;
        aeoi_d         = 1'b0;
        buf_ms_d       = '0;
        sfnm_d         = 1'b0;
        init_clear_d   = 1'b1;
        state_d        = WAIT_ICW2;
      end else if (a1_write) begin
        case (state)
          WAIT_ICW2: begin
            vector_base_d = data_q[7:3];
            if (!single)   state_d = WAIT_ICW3;
            else if (ic4)  state_d = WAIT_ICW4;
            else           state_d = READY;
          end
          WAIT_ICW3: begin
            icw3_d  = data_q;
            state_d = ic4 ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: begin
            upm_d    = data_q[0];
            aeoi_d   = data_q[1];
            buf_ms_d = data_q[3:2];
            sfnm_d   = data_q[4];
            state_d  = READY;
          end
          READY:   imr_d = data_q;
          default: ;
        endcase
      end else if (strb_q[3]) begin
        if (state == READY) begin
          ocw2_valid_d = 1'b1;
          ocw2_cmd_d   = data_q[7:5];
          ocw2_level_d = data_q[2:0];
        end
      end else if (strb_q[4]) begin
        if (state == READY) begin
          if (data_q[1]) read_isr_sel_d = data_q[0];
          if (data_q[6]) smm_d          = data_q[5];
          poll_pulse_d = data_q[2];
        end
      end
    end
  end

endmodule
